ts_rx_decode: RTL and testbench
===============================

# ts_rx_decode

Receive-side training-sequence decoder, the counterpart of the TS sender. It consumes 128-bit TS words from the lane RX path and classifies each word as TS1, TS2 or malformed. It counts consecutive identical TSs against a per-state target and tells the FSM when enough have been received. In USP mode it also extracts the link and lane numbers and hands them to the TS sender through a valid/ack handshake.

## Interface
Parameters:
- CNT_W, 16, width of the consecutive-TS counter (saturating)

Ports:
- clk  in  1  1GHz system clock
- rst_n  in  1  reset, asynchronous, active-low
- ts_info  in  8  FSM state [7:4], sub-state [3:0]
- mode  in  1  `DSP`/`USP`
- rx_ts_valid  in  1  RX word present
- rx_ts  in  128  symbol 0 in [127:120] … symbol 15 in [7:0]
- rx_ts_ready  out  1  word accepted when valid&ready
- rcv_enough  out  1  target count of expected TS reached (sticky)
- rcv_ts_type  out  2  last accepted word: 0 none, 1 TS1, 2 TS2, 3 bad
- rcv_link_num  out  8  extracted link number
- rcv_link_num_vld  out  1  held until update_ack
- rcv_lane_num  out  8  extracted lane number
- rcv_lane_num_vld  out  1  held until update_ack
- update_ack  in  1  sender consumed link/lane update
- err_cnt  out  8  malformed-word count (see Configuration)

## Operation
- Classification (combinational on rx_ts):
  - TS1: sym0==`COM` and sym6..15 all `TS1_IDTFR`.
  - TS2: sym0==`COM` and sym6..15 all `TS2_IDTFR`.
  - Otherwise the word is bad.
- Expected type:
  - `POLL`/`POLL_ACTIVE` expects TS1; other `POLL` sub-states expect TS2.
  - `CFG_COMPLETE` expects TS2; other `CFG` sub-states expect TS1.
  - All other states have no expected type, and rcv_enough stays 0.
- Target:
  - `POLL_ACTIVE` → `RX_NUM_POLL_ACT2CFG`.
  - Other `POLL` sub-states → `RX_NUM_POLL2CFG`.
  - `CFG_COMPLETE` → `RX_NUM_CFG_C2I`.
  - Other `CFG` sub-states → `RX_NUM_CFG_GENERAL`.
- Consecutive counter cons_cnt, updated on each accepted word:
  - Word of the expected type whose sym1, sym2 and sym4 equal the previously accepted word's: cons_cnt+1, saturating at all-ones.
  - Word of the expected type that differs: cons_cnt=1.
  - Wrong type or bad word: cons_cnt=0.
  - rcv_enough sets when cons_cnt≥target and stays set until ts_info changes or cons_cnt is zeroed.
- USP extraction (mode==`USP`), requires the expected type with cons_cnt reaching 2 on an identical pair:
  - `CFG_LW_START`: sym1≠`PADG12` and sym2==`PADG12` → latch rcv_link_num=sym1 and set rcv_link_num_vld.
  - `CFG_LW_ACC` or `CFG_LN_WAIT`: sym1≠PAD and sym2≠PAD → latch rcv_link_num=sym1 and rcv_lane_num=sym2, set both vld.
  - Extraction fires only on the cycle cons_cnt transitions 1→2 and never re-fires for the same run.
- DSP mode: no extraction; the link/lane outputs stay 0.
- Handshake:
  - rx_ts_ready = ~(rcv_link_num_vld | rcv_lane_num_vld). Intake stalls while an update is pending.
  - update_ack clears both vld flags on the next edge.
  - Latched numbers hold their value after ack.
  - update_ack while no vld is set is ignored.
- ts_info change:
  - Detected as ts_info≠info_reg (a registered copy).
  - That cycle clears cons_cnt, rcv_enough, the vld flags, the previous-word register and rcv_ts_type.
  - A word accepted in the same cycle is dropped: not counted, not classified.

## Timing
- Reset values: rx_ts_ready=1; all other outputs 0; info_reg=0; cons_cnt=0.
- A word accepted at edge N produces the following at edge N+1:
  - rcv_ts_type updated.
  - cons_cnt updated.
  - rcv_enough, plus vld/link/lane when applicable.
- rx_ts_ready falls in the same cycle the vld flag rises. Ack at edge M → ready high after edge M.
- Back-to-back words accepted every cycle when no update is pending.
- Asserting rst_n low mid-run returns everything to reset values immediately (asynchronous). Reset release is synchronised by the top-level reset bridge.

## Configuration
- TSA_ERR_CNT_EN defined:
  - err_cnt increments on each accepted bad word, saturating at 8'hFF.
  - Cleared only by reset, not by ts_info change.
- TSA_ERR_CNT_EN undefined: err_cnt is tied to 8'h00 and its counter register is removed.

## Structure
- define.v holds the constants: `COM`, `PADG12`, `TS1_IDTFR`, `TS2_IDTFR`, `POLL`/`CFG` state and sub-state codes, `DSP`/`USP`, and all `RX_NUM_*` targets, adding `RX_NUM_POLL2CFG`.
- Sub-module ts_rx_classify: combinational 128-bit → {is_ts1, is_ts2, link, lane, rate}. It is instantiated once.

## Test plan
- POLL_ACTIVE; 8 identical TS1 (link/lane PAD) back-to-back → cons_cnt=8; rcv_enough rises the edge after the `RX_NUM_POLL_ACT2CFG`-th word.
- POLL_ACTIVE; 3 TS1, then one word with sym7=8'h00, then 2 TS1 → rcv_ts_type=3 then 1; cons_cnt 3→0→2; err_cnt=1 with the macro, 0 without.
- USP, CFG_LW_START; two TS1 with sym1=8'h05, sym2=PAD → rcv_link_num=8'h05 and vld=1; ready=0; a held third word is not consumed until update_ack; vld clears the edge after ack.
- USP, CFG_LW_ACC; two TS1 with link 8'h05, lane 8'h02 → both vld and values; DSP in the same sequence → vld stays 0.
- ts_info POLL_ACTIVE→CFG_LW_START while rcv_enough=1 and a word is offered → rcv_enough=0, cons_cnt=0, word dropped.
- rst_n asserted mid-run with vld pending → all outputs 0 and ready=1 without a clock edge.

Source files
------------

// File: rtl/ts_rx_decode_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ts_rx_decode_pkg                                                 |
// | Brief   : Symbol codes, state codes, TS-count targets and helper functions |
// |           shared by the training-sequence receive decoder.                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package ts_rx_decode_pkg;

    localparam logic [7:0] c_com       = 8'hBC;
    localparam logic [7:0] c_padg12    = 8'hF7;
    localparam logic [7:0] c_ts1_idtfr = 8'h4A;
    localparam logic [7:0] c_ts2_idtfr = 8'h45;

    localparam logic [3:0] c_st_poll = 4'h2;
    localparam logic [3:0] c_st_cfg  = 4'h3;

    localparam logic [3:0] c_sub_poll_active  = 4'h0;
    localparam logic [3:0] c_sub_poll_config  = 4'h1;
    localparam logic [3:0] c_sub_cfg_lw_start = 4'h0;
    localparam logic [3:0] c_sub_cfg_lw_acc   = 4'h1;
    localparam logic [3:0] c_sub_cfg_ln_wait  = 4'h2;
    localparam logic [3:0] c_sub_cfg_ln_acc   = 4'h3;
    localparam logic [3:0] c_sub_cfg_complete = 4'h4;
    localparam logic [3:0] c_sub_cfg_idle     = 4'h5;

    localparam logic c_dsp = 1'b0;
    localparam logic c_usp = 1'b1;

    localparam logic [15:0] c_rx_num_poll_act2cfg = 16'd8;
    localparam logic [15:0] c_rx_num_poll2cfg     = 16'd8;
    localparam logic [15:0] c_rx_num_cfg_c2i      = 16'd8;
    localparam logic [15:0] c_rx_num_cfg_general  = 16'd2;

    typedef enum logic [1:0] {
        TS_NONE = 2'd0,
        TS_TS1  = 2'd1,
        TS_TS2  = 2'd2,
        TS_BAD  = 2'd3
    } ts_type_e;

    // TS_NONE means the state has no expected type and never reports enough.
    function automatic ts_type_e exp_type_of(input logic [7:0] info);
        ts_type_e t;
        t = TS_NONE;
        if (info[7:4] == c_st_poll)
            t = (info[3:0] == c_sub_poll_active) ? TS_TS1 : TS_TS2;
        else if (info[7:4] == c_st_cfg)
            t = (info[3:0] == c_sub_cfg_complete) ? TS_TS2 : TS_TS1;
        return t;
    endfunction

    function automatic logic [15:0] target_of(input logic [7:0] info);
        logic [15:0] n;
        n = 16'd0;
        if (info[7:4] == c_st_poll)
            n = (info[3:0] == c_sub_poll_active) ? c_rx_num_poll_act2cfg : c_rx_num_poll2cfg;
        else if (info[7:4] == c_st_cfg)
            n = (info[3:0] == c_sub_cfg_complete) ? c_rx_num_cfg_c2i : c_rx_num_cfg_general;
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ts_rx_classify.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ts_rx_classify                                                   |
// | Brief   : Combinational TS1/TS2 detection and field extraction of a        |
// |           128-bit training-sequence word (symbol 0 in the top byte).       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ts_rx_classify
    import ts_rx_decode_pkg::*;
(
    input  logic [127:0] ts,
    output logic         is_ts1,
    output logic         is_ts2,
    output logic [7:0]   link,
    output logic [7:0]   lane,
    output logic [7:0]   rate
);

    logic w_all_ts1;
    logic w_all_ts2;
    // Symbols 3 and 5 carry nothing this decoder acts on.
    logic w_unused_syms;

    always_comb begin
        w_all_ts1 = 1'b1;
        w_all_ts2 = 1'b1;
        for (int i = 6; i < 16; i++) begin
            w_all_ts1 = w_all_ts1 & (ts[127-8*i -: 8] == c_ts1_idtfr);
            w_all_ts2 = w_all_ts2 & (ts[127-8*i -: 8] == c_ts2_idtfr);
        end
    end

    assign is_ts1        = (ts[127:120] == c_com) & w_all_ts1;
    assign is_ts2        = (ts[127:120] == c_com) & w_all_ts2;
    assign link          = ts[119:112];
    assign lane          = ts[111:104];
    assign rate          = ts[95:88];
    assign w_unused_syms = ^{ts[103:96], ts[87:80]};

endmodule
`default_nettype wire

// File: rtl/ts_rx_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ts_rx_decode                                                     |
// | Brief   : TS receive decoder: classifies words, counts consecutive         |
// |           identical TSs, extracts link/lane numbers in USP mode.           |
// |           Optional malformed-word counter: define TSA_ERR_CNT_EN.          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module ts_rx_decode
    import ts_rx_decode_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   ts_info,
    input  logic         mode,
    input  logic         rx_ts_valid,
    input  logic [127:0] rx_ts,
    output logic         rx_ts_ready,
    output logic         rcv_enough,
    output logic [1:0]   rcv_ts_type,
    output logic [7:0]   rcv_link_num,
    output logic         rcv_link_num_vld,
    output logic [7:0]   rcv_lane_num,
    output logic         rcv_lane_num_vld,
    input  logic         update_ack,
    output logic [7:0]   err_cnt
);

    logic             w_is_ts1;
    logic             w_is_ts2;
    logic [7:0]       w_link;
    logic [7:0]       w_lane;
    logic [7:0]       w_rate;
    logic [23:0]      w_key;
    logic             w_info_chg;
    logic             w_take;
    logic             w_match;
    logic             w_same;
    logic             w_extract;
    logic             w_set_link;
    logic             w_set_lane;
    logic             w_enough_nxt;
    logic [CNT_W-1:0] w_cons_nxt;
    logic [CNT_W-1:0] w_target;
    ts_type_e         w_exp;
    ts_type_e         w_word_type;

    logic [7:0]       r_info;
    logic [CNT_W-1:0] r_cons;
    logic             r_enough;
    ts_type_e         r_type;
    logic [23:0]      r_prev;
    logic             r_link_vld;
    logic             r_lane_vld;
    logic [7:0]       r_link;
    logic [7:0]       r_lane;

    ts_rx_classify u_classify (
        .ts     (rx_ts),
        .is_ts1 (w_is_ts1),
        .is_ts2 (w_is_ts2),
        .link   (w_link),
        .lane   (w_lane),
        .rate   (w_rate)
    );

    assign w_key       = {w_link, w_lane, w_rate};
    assign w_info_chg  = (ts_info != r_info);
    assign w_exp       = exp_type_of(ts_info);
    assign w_target    = CNT_W'(target_of(ts_info));
    assign rx_ts_ready = ~(r_link_vld | r_lane_vld);
    // A word arriving with a state change is consumed but otherwise ignored.
    assign w_take      = rx_ts_valid & rx_ts_ready & ~w_info_chg;

    always_comb begin
        w_word_type = TS_BAD;
        if (w_is_ts1)
            w_word_type = TS_TS1;
        else if (w_is_ts2)
            w_word_type = TS_TS2;
    end

    assign w_match = (w_exp != TS_NONE) & (w_word_type == w_exp);
    assign w_same  = (w_key == r_prev);

    always_comb begin
        w_cons_nxt = '0;
        if (w_match) begin
            if (!w_same)
                w_cons_nxt = CNT_W'(1);
            else if (r_cons == {CNT_W{1'b1}})
                w_cons_nxt = r_cons;
            else
                w_cons_nxt = r_cons + CNT_W'(1);
        end
    end

    assign w_enough_nxt = (w_cons_nxt != '0) & (r_enough | (w_cons_nxt >= w_target));

    // The 1->2 step of an identical run happens exactly once per run.
    assign w_extract  = w_take & (mode == c_usp) & w_match & w_same
                      & (r_cons == CNT_W'(1)) & (ts_info[7:4] == c_st_cfg);
    assign w_set_link = w_extract & (w_link != c_padg12)
                      & (((ts_info[3:0] == c_sub_cfg_lw_start) & (w_lane == c_padg12))
                       | (((ts_info[3:0] == c_sub_cfg_lw_acc) | (ts_info[3:0] == c_sub_cfg_ln_wait))
                          & (w_lane != c_padg12)));
    assign w_set_lane = w_extract & (w_link != c_padg12) & (w_lane != c_padg12)
                      & ((ts_info[3:0] == c_sub_cfg_lw_acc) | (ts_info[3:0] == c_sub_cfg_ln_wait));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_info     <= 8'h00;
            r_cons     <= '0;
            r_enough   <= 1'b0;
            r_type     <= TS_NONE;
            r_prev     <= 24'h0;
            r_link_vld <= 1'b0;
            r_lane_vld <= 1'b0;
            r_link     <= 8'h00;
            r_lane     <= 8'h00;
        end else begin
            r_info <= ts_info;
            if (w_info_chg) begin
                r_cons     <= '0;
                r_enough   <= 1'b0;
                r_type     <= TS_NONE;
                r_prev     <= 24'h0;
                r_link_vld <= 1'b0;
                r_lane_vld <= 1'b0;
            end else begin
                if (w_take) begin
                    r_cons   <= w_cons_nxt;
                    r_enough <= w_enough_nxt;
                    r_type   <= w_word_type;
                    r_prev   <= w_key;
                end
                if (update_ack) begin
                    r_link_vld <= 1'b0;
                    r_lane_vld <= 1'b0;
                end
                if (w_set_link) begin
                    r_link     <= w_link;
                    r_link_vld <= 1'b1;
                end
                if (w_set_lane) begin
                    r_lane     <= w_lane;
                    r_lane_vld <= 1'b1;
                end
            end
        end
    end

`ifdef TSA_ERR_CNT_EN
    logic [7:0] r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err <= 8'h00;
        else if (w_take && (w_word_type == TS_BAD) && (r_err != 8'hFF))
            r_err <= r_err + 8'h01;
    end

    assign err_cnt = r_err;
`else
    assign err_cnt = 8'h00;
`endif

    assign rcv_enough       = r_enough;
    assign rcv_ts_type      = r_type;
    assign rcv_link_num     = r_link;
    assign rcv_link_num_vld = r_link_vld;
    assign rcv_lane_num     = r_lane;
    assign rcv_lane_num_vld = r_lane_vld;

endmodule
`default_nettype wire

// File: tb/tb_ts_rx_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ts_rx_decode                                                  |
// | Brief   : Directed bench for ts_rx_decode with a history-based model.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_ts_rx_decode;
    import ts_rx_decode_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   ts_info = 8'h00;
    logic         mode = 1'b0;
    logic         rx_ts_valid = 1'b0;
    logic [127:0] rx_ts = '0;
    logic         rx_ts_ready;
    logic         rcv_enough;
    logic [1:0]   rcv_ts_type;
    logic [7:0]   rcv_link_num;
    logic         rcv_link_num_vld;
    logic [7:0]   rcv_lane_num;
    logic         rcv_lane_num_vld;
    logic         update_ack = 1'b0;
    logic [7:0]   err_cnt;

    int errors = 0;
    int checks = 0;

`ifdef TSA_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    ts_rx_decode #(.CNT_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ts_info          (ts_info),
        .mode             (mode),
        .rx_ts_valid      (rx_ts_valid),
        .rx_ts            (rx_ts),
        .rx_ts_ready      (rx_ts_ready),
        .rcv_enough       (rcv_enough),
        .rcv_ts_type      (rcv_ts_type),
        .rcv_link_num     (rcv_link_num),
        .rcv_link_num_vld (rcv_link_num_vld),
        .rcv_lane_num     (rcv_lane_num),
        .rcv_lane_num_vld (rcv_lane_num_vld),
        .update_ack       (update_ack),
        .err_cnt          (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] make_ts(input logic [7:0] id, input logic [7:0] link,
                                             input logic [7:0] lane);
        return {c_com, link, lane, 8'h00, 8'h01, 8'h00, {10{id}}};
    endfunction

    // ---------------- reference model ----------------
    function automatic int bench_type(input logic [127:0] w);
        logic [7:0] s;
        bit t1 = (w[127:120] == c_com);
        bit t2 = (w[127:120] == c_com);
        for (int i = 6; i < 16; i++) begin
            s = w[127-8*i -: 8];
            if (s != c_ts1_idtfr) t1 = 0;
            if (s != c_ts2_idtfr) t2 = 0;
        end
        return t1 ? 1 : (t2 ? 2 : 3);
    endfunction

    function automatic int bench_exp(input logic [7:0] info);
        if (info[7:4] == c_st_poll) return (info[3:0] == c_sub_poll_active) ? 1 : 2;
        if (info[7:4] == c_st_cfg)  return (info[3:0] == c_sub_cfg_complete) ? 2 : 1;
        return 0;
    endfunction

    function automatic int bench_target(input logic [7:0] info);
        if (info[7:4] == c_st_poll)
            return (info[3:0] == c_sub_poll_active) ? int'(c_rx_num_poll_act2cfg) : int'(c_rx_num_poll2cfg);
        return (info[3:0] == c_sub_cfg_complete) ? int'(c_rx_num_cfg_c2i) : int'(c_rx_num_cfg_general);
    endfunction

    // History of words accepted since the last state change: expected-type flag and sym1/2/4.
    bit          ok_q[$];
    logic [23:0] key_q[$];
    logic [7:0]  m_info;
    int          m_type, m_err;
    bit          m_vl, m_vn;
    logic [7:0]  m_link, m_lane;
    int          m_t;
    bit          m_ok;

    function automatic int trail_run();
        int n = 0;
        for (int i = ok_q.size() - 1; i >= 0; i--) begin
            if (!ok_q[i] || key_q[i] != key_q[ok_q.size()-1]) break;
            n++;
        end
        return n;
    endfunction

    function automatic bit calc_enough();
        int run = 0;
        bit en = 0;
        for (int i = 0; i < ok_q.size(); i++) begin
            if (!ok_q[i]) begin
                run = 0;
                en  = 0;
            end else begin
                run = (i > 0 && ok_q[i-1] && key_q[i] == key_q[i-1]) ? run + 1 : 1;
                if (run >= bench_target(m_info)) en = 1;
            end
        end
        return en;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ok_q.delete(); key_q.delete();
            m_info = 8'h00; m_type = 0; m_err = 0;
            m_vl = 0; m_vn = 0; m_link = 8'h00; m_lane = 8'h00;
        end else if (ts_info != m_info) begin
            ok_q.delete(); key_q.delete();
            m_type = 0; m_vl = 0; m_vn = 0;
            m_info = ts_info;
        end else begin
            if (rx_ts_valid && !(m_vl || m_vn)) begin
                m_t = bench_type(rx_ts);
                m_type = m_t;
                m_ok = (bench_exp(ts_info) != 0) && (m_t == bench_exp(ts_info));
                ok_q.push_back(m_ok);
                key_q.push_back({rx_ts[119:104], rx_ts[95:88]});
                if (m_t == 3 && ERR_EN && m_err < 255) m_err++;
                if (mode == c_usp && m_ok && trail_run() == 2 && ts_info[7:4] == c_st_cfg
                    && rx_ts[119:112] != c_padg12) begin
                    if (ts_info[3:0] == c_sub_cfg_lw_start && rx_ts[111:104] == c_padg12) begin
                        m_link = rx_ts[119:112]; m_vl = 1;
                    end
                    if ((ts_info[3:0] == c_sub_cfg_lw_acc || ts_info[3:0] == c_sub_cfg_ln_wait)
                        && rx_ts[111:104] != c_padg12) begin
                        m_link = rx_ts[119:112]; m_vl = 1;
                        m_lane = rx_ts[111:104]; m_vn = 1;
                    end
                end
            end else if (update_ack) begin
                m_vl = 0; m_vn = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("ready",    rx_ts_ready,      !(m_vl || m_vn));
        chk("ts_type",  rcv_ts_type,      m_type);
        chk("enough",   rcv_enough,       calc_enough());
        chk("link",     rcv_link_num,     m_link);
        chk("link_vld", rcv_link_num_vld, m_vl);
        chk("lane",     rcv_lane_num,     m_lane);
        chk("lane_vld", rcv_lane_num_vld, m_vn);
        chk("err_cnt",  err_cnt,          m_err);
    end

    // ---------------- stimulus ----------------
    task automatic set_info(input logic [7:0] v);
        ts_info = v;
        @(negedge clk);
    endtask

    task automatic send(input logic [127:0] w);
        int n = 0;
        rx_ts = w;
        rx_ts_valid = 1'b1;
        while (!rx_ts_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 1, 0);
        @(negedge clk);
        rx_ts_valid = 1'b0;
    endtask

    logic [127:0] ts1_pad, ts2_pad, bad_w, ts1_l5, ts1_l5n2;

    initial begin
        ts1_pad  = make_ts(c_ts1_idtfr, c_padg12, c_padg12);
        ts2_pad  = make_ts(c_ts2_idtfr, c_padg12, c_padg12);
        ts1_l5   = make_ts(c_ts1_idtfr, 8'h05, c_padg12);
        ts1_l5n2 = make_ts(c_ts1_idtfr, 8'h05, 8'h02);
        bad_w    = ts1_pad;
        bad_w[71:64] = 8'h00;

        #1;
        chk("rst_ready", rx_ts_ready, 1);
        chk("rst_type", rcv_ts_type, 0);
        chk("rst_enough", rcv_enough, 0);
        chk("rst_err", err_cnt, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 8 identical TS1 in POLL_ACTIVE
        set_info({c_st_poll, c_sub_poll_active});
        for (int i = 1; i <= 8; i++) begin
            send(ts1_pad);
            if (i == 7) chk("enough_after7", rcv_enough, 0);
        end
        chk("enough_after8", rcv_enough, 1);
        chk("type_ts1", rcv_ts_type, 1);

        // run broken by a malformed word
        for (int i = 0; i < 3; i++) send(ts1_pad);
        send(bad_w);
        chk("type_bad", rcv_ts_type, 3);
        chk("enough_cleared_bad", rcv_enough, 0);
        chk("err_one", err_cnt, ERR_EN ? 1 : 0);
        send(ts1_pad);
        send(ts1_pad);
        chk("type_after_bad", rcv_ts_type, 1);

        // POLL_CONFIG expects TS2; a TS1 there is the wrong type
        set_info({c_st_poll, c_sub_poll_config});
        send(ts2_pad);
        send(ts2_pad);
        chk("type_ts2", rcv_ts_type, 2);
        send(ts1_pad);

        // state change while enough is set and a word is offered
        set_info({c_st_poll, c_sub_poll_active});
        for (int i = 0; i < 8; i++) send(ts1_pad);
        chk("enough_pre_chg", rcv_enough, 1);
        ts_info = {c_st_cfg, c_sub_cfg_lw_start};
        rx_ts = ts1_pad;
        rx_ts_valid = 1'b1;
        @(negedge clk);
        rx_ts_valid = 1'b0;
        chk("enough_chg", rcv_enough, 0);
        chk("type_chg", rcv_ts_type, 0);
        send(ts1_pad);
        chk("dropped_word", rcv_enough, 0);

        // DSP: no extraction
        mode = c_dsp;
        set_info({c_st_cfg, c_sub_cfg_lw_acc});
        send(ts1_l5n2);
        send(ts1_l5n2);
        chk("dsp_vld", rcv_link_num_vld, 0);
        chk("dsp_link", rcv_link_num, 0);

        // USP, LW_START: link only, then stall until ack
        mode = c_usp;
        set_info({c_st_cfg, c_sub_cfg_lw_start});
        send(ts1_l5);
        send(ts1_l5);
        chk("usp_link", rcv_link_num, 8'h05);
        chk("usp_link_vld", rcv_link_num_vld, 1);
        chk("usp_ready_low", rx_ts_ready, 0);
        rx_ts = ts1_l5;
        rx_ts_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_ready", rx_ts_ready, 0);
        update_ack = 1'b1;
        @(negedge clk);
        update_ack = 1'b0;
        chk("ack_vld", rcv_link_num_vld, 0);
        chk("ack_link_held", rcv_link_num, 8'h05);
        @(negedge clk);
        rx_ts_valid = 1'b0;
        chk("no_refire", rcv_link_num_vld, 0);

        // ack with nothing pending is ignored
        update_ack = 1'b1;
        @(negedge clk);
        update_ack = 1'b0;

        // USP, LW_ACC: link and lane
        set_info({c_st_cfg, c_sub_cfg_lw_acc});
        send(ts1_l5n2);
        send(ts1_l5n2);
        chk("acc_lane", rcv_lane_num, 8'h02);
        chk("acc_lane_vld", rcv_lane_num_vld, 1);
        chk("acc_link_vld", rcv_link_num_vld, 1);

        // asynchronous reset with an update pending
        #2 rst_n = 1'b0;
        #1;
        chk("async_ready", rx_ts_ready, 1);
        chk("async_link", rcv_link_num, 0);
        chk("async_lane_vld", rcv_lane_num_vld, 0);
        chk("async_enough", rcv_enough, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
